// File: rtl/tdmo_tx_pkg.sv
// Shared definitions for the TDM output block: register sub-addresses,
// channel geometry and the STATUS register layout.
package tdmo_tx_pkg;

    localparam int TDMO_NUM_CH = 32;
    localparam int TDMO_CH_W   = 5;

    localparam logic [15:0] TDMO_START  = 16'h0000;
    localparam logic [15:0] TDMO_STATUS = 16'h0004;
    // Bits [12:8] of a TDMO_ALL read address carry the channel, so they are masked out of the decode.
    localparam logic [15:0] TDMO_ALL      = 16'h2000;
    localparam logic [15:0] TDMO_ALL_MASK = 16'hE0FF;

    typedef struct packed {
        logic [21:0]          rsvd;
        logic                 enable;
        logic                 aligned;
        logic [TDMO_CH_W-1:0] ch;
        logic [2:0]           bit_idx;
    } tdmo_status_t;

    function automatic logic addr_is_all(input logic [15:0] sub_adr);
        return (sub_adr & TDMO_ALL_MASK) == TDMO_ALL;
    endfunction

endpackage

// File: rtl/tdmo_tx_edge_sync.sv
// Multi-flop synchroniser followed by a rising-edge detector whose history
// flop only advances on cycles where 'sample' is high.
module tdmo_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    input  logic sample,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            if (sample) begin
                prev_q <= sync_q[STAGES-1];
            end
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tdmo_tx.sv
// Time Division Multiplexer Out: 32 byte-wide samples written over Wishbone
// and serialised MSb first onto one TDM line, aligned by frame_sync.
module tdmo_tx
    import tdmo_tx_pkg::*;
#(
    parameter int NUM_CH      = TDMO_NUM_CH,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ser_clk,
    input  logic        frame_sync,
    output logic        data_out,
    output logic        new_frame_int,
    input  logic [31:0] i_wb_adr,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    logic                 ser_rise;
    logic                 fs_edge;
    logic                 enable;
    logic                 aligned;
    logic [TDMO_CH_W-1:0] ch_count;
    logic [2:0]           bit_count;
    logic [7:0]           shift_reg;
    logic [7:0]           mem [NUM_CH];

    logic                 wb_req;
    logic                 wb_wr;
    logic                 wb_rd;
    logic                 start_hit;
    logic                 status_hit;
    logic                 all_hit;
    logic                 mem_wr;
    logic [TDMO_CH_W-1:0] wr_ch;
    logic [TDMO_CH_W-1:0] rd_ch;
    logic [TDMO_CH_W-1:0] load_ch;
    logic [7:0]           load_byte;
    tdmo_status_t         status;
    logic                 unused_bits;

    tdmo_edge_sync #(.STAGES(SYNC_STAGES)) u_ser_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (ser_clk),
        .sample   (1'b1),
        .rise     (ser_rise)
    );

    // The frame_sync history only moves on bit-clock edges, so its rise is fs_edge directly.
    tdmo_edge_sync #(.STAGES(SYNC_STAGES)) u_fs_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (frame_sync),
        .sample   (ser_rise),
        .rise     (fs_edge)
    );

    assign wb_req     = i_wb_stb & i_wb_cyc & ~o_wb_ack;
    assign wb_wr      = wb_req & i_wb_we;
    assign wb_rd      = wb_req & ~i_wb_we;
    assign start_hit  = (i_wb_adr[15:0] == TDMO_START);
    assign status_hit = (i_wb_adr[15:0] == TDMO_STATUS);
    assign all_hit    = addr_is_all(i_wb_adr[15:0]);
    assign mem_wr     = wb_wr & all_hit & i_wb_sel[0];
    assign wr_ch      = i_wb_dat[12:8];
    assign rd_ch      = i_wb_adr[12:8];
    assign o_wb_err   = 1'b0;

    assign unused_bits = ^{i_wb_adr[31:16], i_wb_sel[3:1], i_wb_dat[31:13]};

    // A write landing on the channel being loaded this cycle is forwarded straight into shift_reg.
    assign load_ch   = fs_edge ? '0 : ch_count + 5'd1;
    assign load_byte = (mem_wr && (wr_ch == load_ch)) ? i_wb_dat[7:0] : mem[load_ch];

    always_comb begin
        status         = '0;
        status.enable  = enable;
        status.aligned = aligned;
        status.ch      = ch_count;
        status.bit_idx = bit_count;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_wb_ack <= 1'b0;
        end else begin
            o_wb_ack <= wb_req;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable <= 1'b0;
        end else if (wb_wr && start_hit && i_wb_sel[0]) begin
            enable <= i_wb_dat[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (mem_wr) begin
            mem[wr_ch] <= i_wb_dat[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_wb_dat <= 32'h0;
        end else if (wb_rd) begin
            if (status_hit) begin
                o_wb_dat <= status;
            end else if (all_hit) begin
                o_wb_dat <= {19'b0, rd_ch, mem[rd_ch]};
            end else begin
                o_wb_dat <= 32'h0;
            end
        end
    end

    // A frame start in the same cycle as a clearing STATUS read leaves the interrupt set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            new_frame_int <= 1'b0;
        end else begin
            if (wb_rd && status_hit) begin
                new_frame_int <= 1'b0;
            end
            if (enable && ser_rise && fs_edge) begin
                new_frame_int <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= 1'b0;
            aligned   <= 1'b0;
            ch_count  <= '0;
            bit_count <= 3'd7;
            shift_reg <= 8'h00;
        end else if (!enable) begin
            data_out  <= 1'b0;
            aligned   <= 1'b0;
            ch_count  <= '0;
            bit_count <= 3'd7;
        end else if (ser_rise) begin
            if (fs_edge) begin
                shift_reg <= load_byte;
                data_out  <= load_byte[7];
                ch_count  <= '0;
                bit_count <= 3'd6;
                aligned   <= 1'b1;
            end else if (aligned && bit_count != 3'd7) begin
                data_out  <= shift_reg[bit_count];
                bit_count <= bit_count - 3'd1;
            end else if (aligned) begin
                ch_count  <= load_ch;
                shift_reg <= load_byte;
                data_out  <= load_byte[7];
                bit_count <= 3'd6;
            end else begin
                data_out  <= 1'b0;
            end
        end
    end

endmodule
